// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller; start detect, majority mid-bit sampling, deserialise, parity/stop check
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  cnt_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH + 1);

  state_t                r_state;
  logic                  r_armed;
  logic [2:0]            r_smp;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [5:0]            w_half;
  logic                  w_bit;
  logic                  w_mid;
  logic                  w_end;

  assign w_half = prescale >> 1;
  assign w_bit  = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  assign w_mid  = edge_cnt == w_half + 6'd2;
  assign w_end  = edge_cnt == prescale;
  assign busy   = (r_state == START) || (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
  assign cnt_en = busy;

  // three raw samples around mid-bit, voted once the third is in
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_smp <= '0;
    else begin
      if (edge_cnt == w_half - 6'd1) r_smp[0] <= rx_in;
      if (edge_cnt == w_half)        r_smp[1] <= rx_in;
      if (edge_cnt == w_half + 6'd1) r_smp[2] <= rx_in;
    end

  // frame sequencer; the decision at the stop mid-point makes p_data/data_valid visible in DONE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= IDLE;
      r_armed    <= 1'b1;
      r_shreg    <= '0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (!r_armed) r_armed <= rx_in;
          else if (!rx_in) begin
            r_state <= START;
            par_err <= 1'b0;
            stp_err <= 1'b0;
          end
        START:
          if (w_mid && w_bit) r_state <= IDLE;
          else if (w_end && bit_cnt == 4'd1) r_state <= DATA;
        DATA: begin
          if (w_mid) r_shreg <= {w_bit, r_shreg[DATA_WIDTH-1:1]};
          if (w_end && bit_cnt == LAST_DATA) r_state <= par_en ? PARITY : STOP;
        end
        PARITY: begin
          if (w_mid) par_err <= w_bit ^ (^r_shreg) ^ par_typ;
          if (w_end) r_state <= STOP;
        end
        STOP:
          if (w_mid) begin
            stp_err <= ~w_bit;
            r_state <= DONE;
            if (w_bit && !par_err) begin
              p_data     <= r_shreg;
              data_valid <= 1'b1;
            end
          end
        DONE: begin
          data_valid <= 1'b0;
          if (stp_err) r_armed <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed table plus hand sequences for the UART RX controller
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       cnt_en, data_valid, par_err, stp_err, busy;
  logic [7:0] p_data;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .par_typ(par_typ), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .cnt_en(cnt_en),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // external edge/bit counter behaviour
  always @(posedge clk or negedge rst)
    if (!rst) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (!cnt_en) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else begin
      edge_cnt <= (edge_cnt == prescale) ? 6'd1 : edge_cnt + 6'd1;
      if (bit_cnt == 4'd0) bit_cnt <= 4'd1;
      else if (edge_cnt == prescale) bit_cnt <= bit_cnt + 4'd1;
    end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         dv_cnt = 0;
  int         busy_cnt = 0;
  int         dv_cyc = 0;
  logic [7:0] dv_log [16];
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_log[dv_cnt % 16] = p_data;
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic sb, input int gbit, output int t0);
    int  n;
    int  p;
    logic v;
    n = pe ? 11 : 10;
    p = int'(prescale);
    for (int k = 0; k < n; k++) begin
      v = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : (pe && k == 9) ? pb : sb;
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) t0 = cyc;
        rx_in = (k == gbit && c == p / 2 + 1) ? ~v : v;
      end
    end
  endtask

  typedef struct {
    int         p;
    logic       pe;
    logic       pt;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    int         gbit;
    int         ndv;
    logic [7:0] pdata;
    logic       perr;
    logic       serr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t0;
    int b_dv;
    int b_busy;
    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{32, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, -1, 1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1, 0, 8'h55, 1'b0, 1'b1};
    vecs[5] = '{8,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1,  3, 1, 8'hC3, 1'b0, 1'b0};
    vecs[6] = '{16, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1,  9, 1, 8'h81, 1'b0, 1'b0};
    vecs[7] = '{8,  1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, -1, 0, 8'h81, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_p_data", 32'(p_data), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_par_err", 32'(par_err), 32'h0);
    chk("rst_stp_err", 32'(stp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt_en", 32'(cnt_en), 32'h0);
    rst = 1'b1;
    idle(4);

    for (int i = 0; i < 8; i++) begin
      prescale = 6'(vecs[i].p);
      par_en   = vecs[i].pe;
      par_typ  = vecs[i].pt;
      b_dv     = dv_cnt;
      send_frame(vecs[i].d, vecs[i].pe, vecs[i].pb, vecs[i].sb, vecs[i].gbit, t0);
      idle(3 * vecs[i].p);
      chk($sformatf("v%0d_dv_count", i), 32'(dv_cnt - b_dv), 32'(vecs[i].ndv));
      chk($sformatf("v%0d_p_data", i), 32'(p_data), 32'(vecs[i].pdata));
      chk($sformatf("v%0d_par_err", i), 32'(par_err), 32'(vecs[i].perr));
      chk($sformatf("v%0d_stp_err", i), 32'(stp_err), 32'(vecs[i].serr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
      if (vecs[i].ndv == 1)
        chk($sformatf("v%0d_latency", i), 32'(dv_cyc - t0),
            32'((9 + int'(vecs[i].pe)) * vecs[i].p + vecs[i].p / 2 + 4));
    end

    // short low pulse: START aborts at the mid-bit vote
    prescale = 6'd8;
    par_en   = 1'b0;
    b_dv     = dv_cnt;
    b_busy   = busy_cnt;
    repeat (3) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(20);
    chk("glitch_busy_cycles", 32'(busy_cnt - b_busy), 32'd7);
    chk("glitch_dv", 32'(dv_cnt - b_dv), 32'd0);
    chk("glitch_par_err", 32'(par_err), 32'h0);
    chk("glitch_stp_err", 32'(stp_err), 32'h0);
    chk("glitch_cnt_en", 32'(cnt_en), 32'h0);

    // back-to-back frames with no idle gap
    b_dv = dv_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, t0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(24);
    chk("b2b_dv_count", 32'(dv_cnt - b_dv), 32'd2);
    chk("b2b_first", 32'(dv_log[b_dv % 16]), 32'h12);
    chk("b2b_second", 32'(dv_log[(b_dv + 1) % 16]), 32'h34);

    // break: line stays low after a bad stop bit
    prescale = 6'd32;
    par_en   = 1'b1;
    par_typ  = 1'b1;
    b_dv     = dv_cnt;
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1, t0);
    @(posedge clk);
    b_busy = busy_cnt;
    repeat (200) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    @(posedge clk);
    chk("break_busy_cycles", 32'(busy_cnt - b_busy), 32'd0);
    chk("break_stp_err", 32'(stp_err), 32'h1);
    chk("break_par_err", 32'(par_err), 32'h0);
    chk("break_dv", 32'(dv_cnt - b_dv), 32'd0);
    idle(4);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, -1, t0);
    idle(96);
    chk("rearm_dv", 32'(dv_cnt - b_dv), 32'd1);
    chk("rearm_p_data", 32'(p_data), 32'h55);
    chk("rearm_stp_err", 32'(stp_err), 32'h0);

    // asynchronous reset in the middle of the data bits
    prescale = 6'd8;
    par_en   = 1'b0;
    b_dv     = dv_cnt;
    repeat (8) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    repeat (12) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
    chk("mid_busy", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_cnt_en", 32'(cnt_en), 32'h0);
    chk("arst_p_data", 32'(p_data), 32'h0);
    chk("arst_dv", 32'(data_valid), 32'h0);
    chk("arst_flags", 32'({par_err, stp_err}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(10);
    send_frame(8'hE7, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(24);
    chk("post_rst_dv", 32'(dv_cnt - b_dv), 32'd1);
    chk("post_rst_p_data", 32'(p_data), 32'hE7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-path controller for the UART RX.
- Detects the start bit, sequences the external edge/bit counter through start, data, optional parity and stop bits, and majority-samples rx_in mid-bit.
- Deserializes data LSB-first, then checks parity and stop.
- Delivers p_data with a one-cycle data_valid pulse to the frame consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame; DATA_WIDTH+3 must be <= 15.

Ports:
clk  input  1  receiver oversampling clock
rst  input  1  reset; asynchronous, active-low
rx_in  input  1  serial line, synchronised upstream, idle high
prescale  input  6  oversampling ratio; legal values 8, 16, 32; stable while busy
par_en  input  1  1 = parity bit present
par_typ  input  1  0 = even parity, 1 = odd parity
edge_cnt  input  6  from edge/bit counter: edge index within current bit
bit_cnt  input  4  from edge/bit counter: 1 = start bit, 2..DATA_WIDTH+1 = data, then parity/stop
cnt_en  output  1  enable to edge/bit counter; deasserting resets both counts to 0
p_data  output  DATA_WIDTH  last good frame's data
data_valid  output  1  one-cycle pulse, p_data updated
par_err  output  1  parity mismatch on last frame
stp_err  output  1  stop bit sampled low on last frame
busy  output  1  frame in progress

Behaviour:
- Reset (async, rst low): state IDLE, armed=1, p_data=0, data_valid=0, par_err=0, stp_err=0, sample regs 0, shift reg 0. Reset mid-frame aborts the frame with no data_valid.
- Counter contract:
  - While cnt_en=1, edge_cnt runs 1..prescale and wraps to 1.
  - bit_cnt goes 0->1 on the first enabled cycle and increments when edge_cnt==prescale.
- cnt_en and busy are combinational: high in START, DATA, PARITY, STOP; low in IDLE, DONE.
- Sampling, with H = prescale>>1:
  - Capture rx_in into s0, s1, s2 at edge_cnt == H-1, H, H+1.
  - At edge_cnt == H+2 the sampled bit is s = majority(s0,s1,s2).
- States:
  - IDLE:
    - If armed=0, wait for rx_in==1, then set armed=1.
    - If armed=1 and rx_in==0, go to START next cycle.
  - START:
    - On entry, clear par_err and stp_err.
    - At edge_cnt==H+2, if s==1 (glitch), go to IDLE next cycle; no error flags, no data_valid.
    - Else at edge_cnt==prescale with bit_cnt==1, go to DATA.
  - DATA:
    - At edge_cnt==H+2, shift s into the shift register LSB-first: shreg <= {s, shreg[DATA_WIDTH-1:1]}.
    - At edge_cnt==prescale with bit_cnt==DATA_WIDTH+1, go to PARITY if par_en, else STOP.
  - PARITY:
    - At edge_cnt==H+2, par_err <= s XOR (^shreg) XOR par_typ.
    - At edge_cnt==prescale, go to STOP.
  - STOP:
    - At edge_cnt==H+2, stp_err <= ~s and go to DONE next cycle.
    - The early exit leaves half a bit of margin for back-to-back frames.
  - DONE (exactly one cycle):
    - If par_err==0 and the stop bit is good: p_data <= shreg, data_valid=1 this cycle (registered, one pulse).
    - If stop is bad: armed <= 0.
    - Always go to IDLE.
- Errors:
  - par_err and stp_err hold until the next START entry.
  - p_data is unchanged on any errored frame.
- par_en=0: parity state skipped; par_err stays 0.
- prescale outside {8,16,32}: behaviour undefined, not checked.
- rx_in held low continuously (break): frame completes with stp_err=1, then IDLE waits for rx_in high before re-arming; no repeated frames.
- Latency: data_valid asserts one cycle after the stop-bit decision at edge_cnt==H+2.

Test Plan:
1. prescale=8, par_en=0, frame 0xA5 (LSB first), stop=1 -> data_valid single pulse, p_data=0xA5, par_err=0, stp_err=0; samples at edge_cnt 3,4,5, decided at 6.
2. prescale=16, par_en=1, par_typ=0: send 0x3C with parity 0 -> data_valid, p_data=0x3C; resend with parity 1 -> par_err=1, no data_valid, p_data stays 0x3C.
3. prescale=8, rx_in low for 3 cycles only -> START aborts at edge_cnt==6, returns to IDLE, cnt_en=0, no flags, no data_valid.
4. prescale=32, par_en=1, par_typ=1, 0x01 with stop bit 0 -> stp_err=1, no data_valid; rx_in held low afterwards -> stays IDLE until rx_in high, then next frame 0x55 accepted.
5. Back-to-back frames 0x12 then 0x34 at prescale=8 with no idle gap -> two data_valid pulses, p_data 0x12 then 0x34.
6. Single glitch sample inverted at edge H within a data bit -> majority corrects it, expected byte received. Async rst low mid-DATA -> all outputs 0 immediately; next clean frame received correctly.
